// File: rtl/acc_sign_responder_if.sv
// ============================================================================
// acc_sign_responder_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles the signals between the accumulator sign responder and the
//   blocks around it: the sign-test request from the control section, the
//   circulating accumulator word, and the responder's answer/status lines.
//
// Signals:
//   dv          control -> responder  sign-test request pulse (one cycle)
//   c25         control -> responder  E order: jump if Acc >= 0
//   c10         control -> responder  G order: jump if Acc < 0
//   jump_uc     control -> responder  unconditional jump
//   acc_d0      acc     -> responder  digit-0 marker of the circulating word
//   acc_bit     acc     -> responder  current serial accumulator digit
//   acc_write   acc     -> responder  accumulator being modified this cycle
//   dv_d        responder -> control  one-cycle pulse: jump taken
//   test_done   responder -> control  one-cycle pulse: request resolved
//   sign_valid  responder -> control  stored sign matches the accumulator
//   acc_neg     responder -> control  stored sign bit (1 = negative)
//   proto_err   responder -> control  sticky protocol error flag
//
// Modports:
//   master  the side that drives requests and the accumulator stream
//   slave   the responder itself
// ============================================================================
interface acc_sign_responder_if;

    logic dv;
    logic c25;
    logic c10;
    logic jump_uc;
    logic acc_d0;
    logic acc_bit;
    logic acc_write;

    logic dv_d;
    logic test_done;
    logic sign_valid;
    logic acc_neg;
    logic proto_err;

    modport master (
        output dv,
        output c25,
        output c10,
        output jump_uc,
        output acc_d0,
        output acc_bit,
        output acc_write,
        input  dv_d,
        input  test_done,
        input  sign_valid,
        input  acc_neg,
        input  proto_err
    );

    modport slave (
        input  dv,
        input  c25,
        input  c10,
        input  jump_uc,
        input  acc_d0,
        input  acc_bit,
        input  acc_write,
        output dv_d,
        output test_done,
        output sign_valid,
        output acc_neg,
        output proto_err
    );

endinterface

// File: rtl/acc_sign_responder.sv
// ============================================================================
// acc_sign_responder
// ----------------------------------------------------------------------------
// Purpose:
//   Accumulator-side responder to the control section's sign-test pulse (dv)
//   for G, E and unconditional-jump orders. It follows the serial, LSB-first
//   accumulator word, captures the sign digit each circulation, and answers
//   each accepted dv with exactly one test_done pulse, accompanied by dv_d
//   when the jump is taken.
//
// Parameters:
//   WORD_BITS   digits per accumulator circulation
//   SIGN_DIGIT  digit index carrying the sign bit (< WORD_BITS)
//   CNT_W       digit counter width (2**CNT_W >= WORD_BITS)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   bus         acc_sign_responder_if.slave: request, accumulator stream and
//               response/status signals
// ============================================================================
module acc_sign_responder #(
    parameter int WORD_BITS  = 36,
    parameter int SIGN_DIGIT = 35,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    acc_sign_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] SIGN_IDX = CNT_W'(SIGN_DIGIT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SIGN,
        ST_RESPOND
    } state_t;

    typedef enum logic [1:0] {
        ORD_NONE,
        ORD_GE,
        ORD_LT,
        ORD_UC
    } order_t;

    state_t           state_q;
    state_t           state_d;
    order_t           order_q;
    order_t           order_d;
    order_t           req_order;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cur_cnt;
    logic             wr_seen_q;
    logic             wr_eff;
    logic             capture;
    logic             at_sign;
    logic             cur_sign;
    logic             sign_ok;

    logic             sign_valid_q;
    logic             acc_neg_q;
    logic             dv_d_q;
    logic             test_done_q;
    logic             proto_err_q;

    logic             go_respond;
    logic             taken_d;
    logic             dv_err;

    // Decide whether an order jumps for a given sign (1 = negative).
    function automatic logic order_taken(input order_t ord, input logic neg);
        logic take;
        take = 1'b0;
        case (ord)
            ORD_UC:  take = 1'b1;
            ORD_GE:  take = ~neg;
            ORD_LT:  take = neg;
            default: take = 1'b0;
        endcase
        return take;
    endfunction

    // The digit-0 marker forces the current digit index to 0, so an early
    // marker simply resynchronises the count. A write flag left over from the
    // previous word is likewise discarded the moment the new word begins.
    // A capture happens only on an untouched word at the sign digit; when the
    // accumulator is being written in the request cycle, the stored sign is
    // already stale and cannot be used to answer.
    always_comb begin
        cur_cnt  = bus.acc_d0 ? '0 : cnt_q;
        wr_eff   = wr_seen_q & ~bus.acc_d0;
        at_sign  = (cur_cnt == SIGN_IDX);
        capture  = at_sign & ~bus.acc_write & ~wr_eff;
        cur_sign = capture ? bus.acc_bit : acc_neg_q;
        sign_ok  = (sign_valid_q & ~bus.acc_write) | capture;
    end

    // Order priority: unconditional jump over E (c25) over G (c10).
    always_comb begin
        req_order = ORD_NONE;
        if (bus.jump_uc) begin
            req_order = ORD_UC;
        end else if (bus.c25) begin
            req_order = ORD_GE;
        end else if (bus.c10) begin
            req_order = ORD_LT;
        end
    end

    // Next-state logic. A request is answered straight away when a sign is
    // available (stored or captured this very cycle); otherwise the order is
    // parked until the next good capture. Requests arriving while one is
    // still outstanding or being answered are dropped and flagged.
    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        go_respond = 1'b0;
        taken_d    = 1'b0;
        dv_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.dv) begin
                    order_d = req_order;
                    if (sign_ok) begin
                        state_d    = ST_RESPOND;
                        go_respond = 1'b1;
                        taken_d    = order_taken(req_order, cur_sign);
                    end else begin
                        state_d = ST_WAIT_SIGN;
                    end
                end
            end

            ST_WAIT_SIGN: begin
                dv_err = bus.dv;
                if (capture) begin
                    state_d    = ST_RESPOND;
                    go_respond = 1'b1;
                    taken_d    = order_taken(order_q, bus.acc_bit);
                end
            end

            ST_RESPOND: begin
                dv_err  = bus.dv;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Digit counter and write tracking for the circulating word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            wr_seen_q <= 1'b0;
        end else begin
            cnt_q     <= (cur_cnt == LAST_IDX) ? '0 : cur_cnt + CNT_W'(1);
            wr_seen_q <= bus.acc_write | wr_eff;
        end
    end

    // Stored sign. Any write invalidates it; the sign digit either refreshes
    // it (clean word) or invalidates it (word was touched this circulation).
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_valid_q <= 1'b0;
            acc_neg_q    <= 1'b0;
        end else begin
            if (capture) begin
                acc_neg_q <= bus.acc_bit;
            end
            if (bus.acc_write) begin
                sign_valid_q <= 1'b0;
            end else if (at_sign) begin
                sign_valid_q <= capture;
            end
        end
    end

    // FSM state, order latch and registered response pulses. dv_d is only
    // ever raised together with test_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            order_q     <= ORD_NONE;
            test_done_q <= 1'b0;
            dv_d_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            test_done_q <= go_respond;
            dv_d_q      <= go_respond & taken_d;
            proto_err_q <= proto_err_q | dv_err;
        end
    end

    assign bus.dv_d       = dv_d_q;
    assign bus.test_done  = test_done_q;
    assign bus.sign_valid = sign_valid_q;
    assign bus.acc_neg    = acc_neg_q;
    assign bus.proto_err  = proto_err_q;

endmodule
